// File: rtl/dram_arbiter.sv
// Two-requester arbiter for a single data memory. Requester 0 has strict priority.
// Define DRAM_ARB_STARVE_GUARD_EN to force a grant to requester 1 after starveLimit consecutive losses.
module dram_arbiter #(
  parameter int addrSize    = 8,
  parameter int DRamWidth   = 8,
  parameter int starveLimit = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [1:0]           ctrl0,
  input  logic [1:0]           ctrl1,
  input  logic [addrSize-1:0]  addr0,
  input  logic [addrSize-1:0]  addr1,
  input  logic [DRamWidth-1:0] wdata0,
  input  logic [DRamWidth-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [DRamWidth-1:0] rdata,
  output logic [1:0]           memCtrl,
  output logic [addrSize-1:0]  memAddr,
  output logic [DRamWidth-1:0] memDataIn,
  input  logic [DRamWidth-1:0] memDataOut,
  input  logic                 memDataReady,
  output logic [1:0]           grant
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, RELEASE} state_t;

  state_t     state, nextState;
  logic [1:0] ctrlLat;
  logic       valid0, valid1, starved, pick1, busy;

  // ctrl 00 and 11 are not operations, so such a request does not exist
  assign valid0 = req0 && (ctrl0 == 2'b01 || ctrl0 == 2'b10);
  assign valid1 = req1 && (ctrl1 == 2'b01 || ctrl1 == 2'b10);
  assign pick1  = valid1 && (!valid0 || starved);
  assign busy   = (state == BUSY0) || (state == BUSY1);

`ifdef DRAM_ARB_STARVE_GUARD_EN
  localparam int cntW = (starveLimit < 1) ? 1 : $clog2(starveLimit + 1);
  localparam logic [cntW-1:0] limitVal = cntW'(starveLimit);

  logic [cntW-1:0] lossCnt;

  assign starved = (lossCnt == limitVal);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lossCnt <= '0;
    end else if (state == IDLE) begin
      if (pick1)
        lossCnt <= '0;
      else if (valid0 && valid1 && !starved)
        lossCnt <= lossCnt + 1'b1;
    end
  end
`else
  // Guard compiled out: strict priority, starveLimit only kept for a uniform interface
  assign starved = 1'b0 & (starveLimit != 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (valid0 || valid1) nextState = pick1 ? BUSY1 : BUSY0;
      BUSY0,
      BUSY1:   if (memDataReady) nextState = RELEASE;
      RELEASE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    memCtrl = busy ? ctrlLat : 2'b00;
    grant   = (state == BUSY0) ? 2'b01 : (state == BUSY1) ? 2'b10 : 2'b00;
  end

  // Access latch, completion pulses and read capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrlLat   <= 2'b00;
      memAddr   <= '0;
      memDataIn <= '0;
      rdata     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (state == IDLE && (valid0 || valid1)) begin
        ctrlLat   <= pick1 ? ctrl1  : ctrl0;
        memAddr   <= pick1 ? addr1  : addr0;
        memDataIn <= pick1 ? wdata1 : wdata0;
      end
      if (busy && memDataReady) begin
        ack0 <= (state == BUSY0);
        ack1 <= (state == BUSY1);
        if (ctrlLat == 2'b01) rdata <= memDataOut;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: a memory model answers accesses after memDelay cycles,
// expected completions are queued at request time and matched as acks appear.
module tb_dram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [1:0] ctrl0, ctrl1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata;
  logic [1:0] memCtrl;
  logic [7:0] memAddr, memDataIn, memDataOut;
  logic       memDataReady;
  logic [1:0] grant;

  int assertCnt = 0;
  int failCnt   = 0;
  int memDelay  = 1;
  int busyCnt   = 0;

  typedef struct {
    bit         port;
    bit         isRead;
    logic [7:0] data;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  sbEntry_t e;
  logic     prevAck0 = 1'b0;
  logic     prevAck1 = 1'b0;

  dram_arbiter #(.addrSize(8), .DRamWidth(8), .starveLimit(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .ctrl0(ctrl0), .ctrl1(ctrl1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .memCtrl(memCtrl), .memAddr(memAddr), .memDataIn(memDataIn),
    .memDataOut(memDataOut), .memDataReady(memDataReady), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory: raises memDataReady for one cycle after memDelay busy cycles
  always @(posedge clk) begin
    #1;
    if (memCtrl != 2'b00 && !memDataReady) begin
      busyCnt++;
      if (busyCnt >= memDelay) begin
        memDataReady = 1'b1;
        busyCnt = 0;
      end
    end else begin
      memDataReady = 1'b0;
      busyCnt = 0;
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      checkVal("ackWidth", 32'({prevAck1, prevAck0}), 0);
      checkVal("relCtrl", 32'(memCtrl), 0);
      if (sbQ.size() == 0) begin
        checkVal("unexpAck", 32'({ack1, ack0}), 0);
      end else begin
        e = sbQ.pop_front();
        checkVal("ackPort", 32'({ack1, ack0}), e.port ? 2 : 1);
        if (e.isRead) checkVal("rdata", 32'(rdata), 32'(e.data));
      end
    end
    prevAck0 = ack0;
    prevAck1 = ack1;
  end

  task automatic waitAck(output int lat);
    lat = 0;
    while (!(ack0 || ack1) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkVal("ackSeen", 32'(ack0 | ack1), 1);
  endtask

  task automatic waitGrant(output logic [1:0] g);
    int n = 0;
    while (grant == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    g = grant;
    checkVal("grantSeen", 32'(grant != 2'b00), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", failCnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [1:0] g;
    int         expG;
    reset = 1'b0;
    req0 = 0; req1 = 0; ctrl0 = 0; ctrl1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    memDataOut = 8'h00; memDataReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rstCtrl", 32'(memCtrl), 0);
    checkVal("rstGrant", 32'(grant), 0);
    checkVal("rstAck", 32'({ack1, ack0}), 0);
    checkVal("rstAddr", 32'(memAddr), 0);
    checkVal("rstDin", 32'(memDataIn), 0);
    checkVal("rstRdata", 32'(rdata), 0);
    reset = 1'b1;

    // Write from requester 0, memory answers in the first busy cycle
    req0 = 1; ctrl0 = 2'b10; addr0 = 8'h20; wdata0 = 8'h5A;
    sbQ.push_back('{port: 1'b0, isRead: 1'b0, data: 8'h00});
    @(negedge clk);
    checkVal("t1Grant", 32'(grant), 1);
    checkVal("t1Ctrl", 32'(memCtrl), 2);
    checkVal("t1Addr", 32'(memAddr), 32'h20);
    checkVal("t1Din", 32'(memDataIn), 32'h5A);
    waitAck(lat);
    checkVal("t1Lat", 32'(lat), 1);
    checkVal("t1Ack0", 32'(ack0), 1);
    req0 = 0;
    @(negedge clk);
    checkVal("t1AckOff", 32'(ack0), 0);
    checkVal("t1Idle", 32'(memCtrl), 0);
    checkVal("t1Rdata", 32'(rdata), 0);

    // Read from requester 1 with a 3-cycle memory
    memDelay = 3; memDataOut = 8'hC3;
    req1 = 1; ctrl1 = 2'b01; addr1 = 8'h33;
    sbQ.push_back('{port: 1'b1, isRead: 1'b1, data: 8'hC3});
    @(negedge clk);
    checkVal("t2Grant", 32'(grant), 2);
    lat = 0;
    while (!ack1 && lat < 40) begin
      checkVal("t2AddrHold", 32'(memAddr), 32'h33);
      checkVal("t2CtrlHold", 32'(memCtrl), 1);
      @(negedge clk);
      lat++;
    end
    checkVal("t2Lat", 32'(lat), 3);
    req1 = 0;
    @(negedge clk);
    checkVal("t2RdataHold", 32'(rdata), 32'hC3);

    // Simultaneous requests: 0 first, then 1 after release
    memDelay = 1; memDataOut = 8'h7E;
    req0 = 1; ctrl0 = 2'b10; addr0 = 8'h40; wdata0 = 8'h11;
    req1 = 1; ctrl1 = 2'b01; addr1 = 8'h41;
    sbQ.push_back('{port: 1'b0, isRead: 1'b0, data: 8'h00});
    sbQ.push_back('{port: 1'b1, isRead: 1'b1, data: 8'h7E});
    @(negedge clk);
    checkVal("t3First", 32'(grant), 1);
    waitAck(lat);
    checkVal("t3WrKeepsRdata", 32'(rdata), 32'hC3);
    req0 = 0;
    waitGrant(g);
    checkVal("t3Second", 32'(g), 2);
    checkVal("t3Addr1", 32'(memAddr), 32'h41);
    waitAck(lat);
    req1 = 0;

    // Both held continuously: starvation behaviour
    memDataOut = 8'h99;
    req0 = 1; ctrl0 = 2'b10; addr0 = 8'h50; wdata0 = 8'hA5;
    req1 = 1; ctrl1 = 2'b01; addr1 = 8'h51;
    for (int i = 0; i < 6; i++) begin
`ifdef DRAM_ARB_STARVE_GUARD_EN
      expG = (i == 4) ? 2 : 1;
`else
      expG = 1;
`endif
      sbQ.push_back('{port: (expG == 2), isRead: (expG == 2), data: 8'h99});
      waitGrant(g);
      checkVal("t4Grant", 32'(g), 32'(expG));
      waitAck(lat);
    end
    req0 = 0; req1 = 0;

    // Reset during BUSY1 abandons the access
    memDelay = 10;
    req1 = 1; ctrl1 = 2'b01; addr1 = 8'h55;
    waitGrant(g);
    checkVal("t5Busy1", 32'(g), 2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkVal("t5Ctrl", 32'(memCtrl), 0);
    checkVal("t5Grant", 32'(grant), 0);
    checkVal("t5Ack", 32'({ack1, ack0}), 0);
    checkVal("t5Addr", 32'(memAddr), 0);
    checkVal("t5Din", 32'(memDataIn), 0);
    checkVal("t5Rdata", 32'(rdata), 0);
    req1 = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkVal("t5NoAck1", 32'(ack1), 0);
    end
    memDelay = 1; memDataOut = 8'h3C;
    req0 = 1; ctrl0 = 2'b01; addr0 = 8'h66;
    sbQ.push_back('{port: 1'b0, isRead: 1'b1, data: 8'h3C});
    @(negedge clk);
    checkVal("t5NewGrant", 32'(grant), 1);
    checkVal("t5NewAddr", 32'(memAddr), 32'h66);
    waitAck(lat);
    checkVal("t5NewLat", 32'(lat), 1);
    req0 = 0;
    @(negedge clk);

    // ctrl 11 / 00 requests are ignored
    req0 = 1; ctrl0 = 2'b11; addr0 = 8'h77;
    req1 = 1; ctrl1 = 2'b00; addr1 = 8'h78;
    repeat (5) begin
      @(negedge clk);
      checkVal("t6Grant", 32'(grant), 0);
      checkVal("t6Ctrl", 32'(memCtrl), 0);
    end
    req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);

    checkVal("sbEmpty", 32'(sbQ.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 The module SHALL have parameter addrSize, default 8, meaning the data-memory address width.
REQ-002 The module SHALL have parameter DRamWidth, default 8, meaning the data-memory word width.
REQ-003 The module SHALL have parameter starveLimit, default 4, meaning the consecutive losses by requester 1 before forced grant.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have ports req0 and req1, input, 1 bit each: access requests from requester 0 (controller, high priority) and requester 1 (I/O port).
REQ-007 The module SHALL have ports ctrl0 and ctrl1, input, 2 bits each: operation, where 01 = read and 10 = write; 00 and 11 are ignored.
REQ-008 The module SHALL have ports addr0 and addr1, input, addrSize bits: access addresses.
REQ-009 The module SHALL have ports wdata0 and wdata1, input, DRamWidth bits: write data.
REQ-010 The module SHALL have ports ack0 and ack1, output, 1 bit: one-cycle completion pulses.
REQ-011 The module SHALL have port rdata, output, DRamWidth bits: registered read data, valid from the ack cycle until the next read completes.
REQ-012 The module SHALL have ports memCtrl (output, 2 bits), memAddr (output, addrSize bits) and memDataIn (output, DRamWidth bits), driven to the memory module.
REQ-013 The module SHALL have ports memDataOut (input, DRamWidth bits) and memDataReady (input, 1 bit): memory read data and completion.
REQ-014 The module SHALL have port grant, output, 2 bits: 00 = none, 01 = requester 0, 10 = requester 1.

Function
REQ-015 The module SHALL implement a state machine with states IDLE, BUSY0, BUSY1 and RELEASE.
REQ-016 In IDLE with a valid request pending, the module SHALL latch the winner's ctrl, addr and wdata on the clock edge and enter BUSY0 or BUSY1 accordingly.
REQ-017 If req0 and req1 are both valid in IDLE, the module SHALL grant requester 0, unless forced by REQ-025.
REQ-018 A request whose ctrl is 00 or 11 SHALL be treated as absent.
REQ-019 In BUSY0 and BUSY1, memCtrl, memAddr and memDataIn SHALL hold the latched values, stable, until memDataReady is sampled high.
REQ-020 On the edge where memDataReady is sampled high in BUSYn, the module SHALL pulse ackn for exactly one cycle, capture memDataOut into rdata (reads only) and enter RELEASE.
REQ-021 In RELEASE, memCtrl SHALL be 00 for exactly one cycle, after which the module SHALL return to IDLE.
REQ-022 The minimum request-to-ack latency SHALL be 2 cycles: one grant cycle plus a memory response in the first BUSY cycle.
REQ-023 A requester SHALL hold reqn until ackn; deasserting reqn mid-BUSY SHALL NOT abort the access.
REQ-024 Write accesses SHALL leave rdata unchanged.
REQ-025 The module SHALL keep a loss counter that increments when req1 is valid but requester 0 is granted, saturating at starveLimit and clearing when requester 1 is granted.
REQ-026 memDataReady sampled high outside BUSY0/BUSY1 SHALL be ignored.

Reset
REQ-027 While reset is low, the module SHALL force the state to IDLE, memCtrl, grant, ack0 and ack1 to 0, memAddr, memDataIn and rdata to 0, and the loss counter to 0, asynchronously.
REQ-028 A reset asserted mid-access SHALL abandon the access with no ack; after release, the first request SHALL be arbitrated from IDLE.

Configuration
REQ-029 With DRAM_ARB_STARVE_GUARD_EN defined, if the loss counter equals starveLimit in IDLE and req1 is valid, the module SHALL grant requester 1 even when req0 is valid.
REQ-030 Without DRAM_ARB_STARVE_GUARD_EN, arbitration SHALL be strict priority to requester 0, and the loss counter logic SHALL be absent.

Verification
REQ-031 The bench SHALL check: after reset, req0 write with ctrl0=10, addr0=0x20, wdata0=0x5A and memDataReady 1 cycle after grant -> memCtrl=10 with addr 0x20, ack0 one pulse, then memCtrl=00 for 1 cycle.
REQ-032 The bench SHALL check: req1 read with addr1=0x33, memDataOut=0xC3 and memDataReady after 3 cycles -> ack1 pulse, rdata=0xC3, and memAddr stable throughout.
REQ-033 The bench SHALL check: req0 and req1 asserted simultaneously -> grant=01 first, then grant=10 after RELEASE.
REQ-034 The bench SHALL check: with the guard enabled and req0 and req1 held continuously -> after 4 requester-0 grants, the 5th grant is 10; with the guard disabled, requester 1 is never granted.
REQ-035 The bench SHALL check: reset pulled low during BUSY1 -> outputs 0 immediately with no ack1; after reset is released, a new req0 is served normally.
REQ-036 The bench SHALL check: req0 with ctrl0=11 -> no grant and memCtrl stays 00.
